// File: rtl/drv_segment_scan.sv
// drv_segment_scan: multiplexed 7-segment scan with a guard gap between digits.
// Optional leading-zero suppression when DRV_SEGMENT_SCAN_LZ_EN is defined.
module drv_segment_scan #(
    parameter int DIGITS    = 8,
    parameter int CLK_DIV   = 100000,
    parameter int GUARD_CYC = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_val,
    input  logic                  i_upd,
    input  logic [DIGITS-1:0]     i_blank,
    output logic [4:0]            o_val,
    output logic [DIGITS-1:0]     o_anode,
    output logic                  o_frame
);

    localparam int PM1 = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
    localparam int PMX = (PM1 > 2) ? PM1 : 2;
    localparam int PW  = $clog2(PMX);
    localparam int IW  = $clog2((DIGITS > 2) ? DIGITS : 2);
    localparam int GL  = ((GUARD_CYC > 0) ? GUARD_CYC : 1) - 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GRD_LAST = PW'(GL);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    localparam logic [0:0] ST_SCAN  = 1'b0;
    localparam logic [0:0] ST_GUARD = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [4:0]          val_q, val_d;
    logic                frame_q, frame_d;

    logic [DIGITS-1:0]   blank_eff;
    logic [3:0]          cur_nib;
    logic                cur_blk;
    logic [IW-1:0]       idx_next;

`ifdef DRV_SEGMENT_SCAN_LZ_EN
    logic [DIGITS-1:0]   lz_supp;

    // Leading zeros from the top digit down are dark; digit 0 always shows.
    always_comb begin
        logic run;
        lz_supp = '0;
        run     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run        = run & (shadow_q[4*k +: 4] == 4'h0);
            lz_supp[k] = run;
        end
        blank_eff = i_blank | lz_supp;
    end
`else
    // Without suppression only the live blank mask darkens a digit.
    always_comb begin
        blank_eff = i_blank;
    end
`endif

    // Pick the nibble and blank flag of the digit currently scanned.
    always_comb begin
        cur_nib = 4'h0;
        cur_blk = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib = shadow_q[4*k +: 4];
                cur_blk = blank_eff[k];
            end
        end
    end

    // Scan FSM: lit period, optional guard gap, then advance the index.
    always_comb begin
        idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        state_d  = state_q;
        idx_d    = idx_q;
        pre_d    = pre_q + 1'b1;
        case (state_q)
            ST_SCAN: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (GUARD_CYC == 0) begin
                        idx_d = idx_next;
                    end else begin
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (pre_q == GRD_LAST) begin
                    pre_d   = '0;
                    state_d = ST_SCAN;
                    idx_d   = idx_next;
                end
            end
            default: begin
                state_d = ST_SCAN;
                pre_d   = '0;
            end
        endcase
        shadow_d = i_upd ? i_val : shadow_q;
    end

    // Output decode from the present state; registered one cycle later.
    always_comb begin
        anode_d = '1;
        val_d   = 5'h10;
        frame_d = 1'b0;
        if (state_q == ST_SCAN) begin
            if (!cur_blk) begin
                anode_d = ~(DIGITS'(1) << idx_q);
                val_d   = {1'b0, cur_nib};
            end
            frame_d = (idx_q == IDX_LAST) && (pre_q == PRE_LAST);
        end
    end

    // State, shadow and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_SCAN;
            idx_q    <= '0;
            pre_q    <= '0;
            shadow_q <= '0;
            anode_q  <= '1;
            val_q    <= 5'h10;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            shadow_q <= shadow_d;
            anode_q  <= anode_d;
            val_q    <= val_d;
            frame_q  <= frame_d;
        end
    end

    assign o_val   = val_q;
    assign o_anode = anode_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_drv_segment_scan.sv
// Directed bench for drv_segment_scan: a guarded and a gapless instance.
// Leading-zero checks run when DRV_SEGMENT_SCAN_LZ_EN is defined.
module tb_drv_segment_scan;

    logic        clk;
    logic        rst;
    logic [15:0] val;
    logic        upd;
    logic [3:0]  blank;
    logic [4:0]  m_val, g_val;
    logic [3:0]  m_an, g_an;
    logic        m_fr, g_fr;
    int          total;
    int          bad;

    drv_segment_scan #(.DIGITS(4), .CLK_DIV(4), .GUARD_CYC(2)) u_m (
        .i_clk(clk), .i_rst(rst), .i_val(val), .i_upd(upd),
        .i_blank(blank), .o_val(m_val), .o_anode(m_an), .o_frame(m_fr)
    );

    drv_segment_scan #(.DIGITS(4), .CLK_DIV(4), .GUARD_CYC(0)) u_g (
        .i_clk(clk), .i_rst(rst), .i_val(val), .i_upd(upd),
        .i_blank(blank), .o_val(g_val), .o_anode(g_an), .o_frame(g_fr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        val = v;
        upd = 1'b1;
        step();
        upd = 1'b0;
    endtask

    task automatic wait_frame(input bit g);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(g ? g_fr : m_fr) && n < 80);
        total++;
        if (!(g ? g_fr : m_fr)) begin
            bad++;
            $display("FAIL frame_timeout g=%0d got=0 want=1", g);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        val = 16'h0;
        upd = 1'b0;
        blank = 4'h0;
        step();
        step();
        total++;
        if (m_an !== 4'hF || m_val !== 5'h10 || m_fr !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got=%h/%h/%b want=f/10/0",
                     m_an, m_val, m_fr);
        end
        rst = 1'b0;
        step();
        total++;
        if (m_an !== 4'hE || m_val !== 5'h00 || g_an !== 4'hE) begin
            bad++;
            $display("FAIL first_lit got=%h/%h/%h want=e/00/e",
                     m_an, m_val, g_an);
        end
    endtask

    task automatic test_scan(input logic [15:0] v, input logic [3:0] dark,
                             input logic [3:0] bl);
        int q, d, r;
        logic lit;
        logic [3:0] ea;
        logic [4:0] ev;
        blank = bl;
        load(v);
        wait_frame(1'b0);
        for (int c = 1; c <= 24; c++) begin
            step();
            lit = 1'b0;
            d = 0;
            if (c >= 3) begin
                q = c - 3;
                d = q / 6;
                r = q % 6;
                lit = (r < 4) && !dark[d];
            end
            ea = lit ? ~(4'b1 << d) : 4'hF;
            ev = lit ? {1'b0, v[4*d +: 4]} : 5'h10;
            total++;
            if (m_an !== ea || m_val !== ev || m_fr !== (c == 24)) begin
                bad++;
                $display("FAIL scan v=%h c=%0d got=%h/%h/%b want=%h/%h/%b",
                         v, c, m_an, m_val, m_fr, ea, ev, (c == 24));
            end
        end
        blank = 4'h0;
    endtask

    task automatic test_no_guard();
        int d;
        logic [3:0] ea;
        logic [4:0] ev;
        load(16'hABCD);
        wait_frame(1'b1);
        for (int c = 1; c <= 16; c++) begin
            step();
            d = (c - 1) / 4;
            ea = ~(4'b1 << d);
            ev = {1'b0, 4'hD - 4'(d)};
            total++;
            if (g_an !== ea || g_val !== ev || g_fr !== (c == 16)) begin
                bad++;
                $display("FAIL no_guard c=%0d got=%h/%h/%b want=%h/%h/%b",
                         c, g_an, g_val, g_fr, ea, ev, (c == 16));
            end
        end
    endtask

    task automatic test_update();
        logic [4:0] ev;
        load(16'h1234);
        wait_frame(1'b0);
        val = 16'hFFFF;
        for (int c = 1; c <= 12; c++) begin
            step();
            ev = 5'h10;
            if (c >= 3 && c <= 6) ev = 5'h04;
            if (c == 9 || c == 10) ev = 5'h03;
            if (c == 11 || c == 12) ev = 5'h0F;
            total++;
            if (m_val !== ev) begin
                bad++;
                $display("FAIL update c=%0d got=%h want=%h", c, m_val, ev);
            end
            if (c == 9) upd = 1'b1;
            if (c == 10) upd = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        load(16'h1234);
        wait_frame(1'b0);
        for (int c = 1; c <= 16; c++) step();
        total++;
        if (m_an !== 4'hB || m_val !== 5'h02) begin
            bad++;
            $display("FAIL pre_rst got=%h/%h want=b/02", m_an, m_val);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (m_an !== 4'hF || m_val !== 5'h10 || m_fr !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%h/%h/%b want=f/10/0",
                     m_an, m_val, m_fr);
        end
        step();
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            total++;
            if (m_an !== ((c < 5) ? 4'hE : 4'hF) ||
                m_val !== ((c < 5) ? 5'h00 : 5'h10)) begin
                bad++;
                $display("FAIL restart c=%0d got=%h/%h", c, m_an, m_val);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_scan(16'h1234, 4'b0000, 4'b0000);
        test_no_guard();
        test_scan(16'h1234, 4'b0100, 4'b0100);
        test_update();
        test_async_reset();
`ifdef DRV_SEGMENT_SCAN_LZ_EN
        test_scan(16'h0050, 4'b1100, 4'b0000);
        test_scan(16'h0000, 4'b1110, 4'b0000);
`else
        test_scan(16'h0050, 4'b0000, 4'b0000);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drv_segment_scan.md
Name: drv_segment_scan

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- Sits directly upstream of the single-digit hex segment driver: selects one digit at a time, presents its 5-bit code to the driver and drives that digit's anode.
- Inserts a guard interval with all anodes off between digits to suppress ghosting.
- Supports per-digit blanking and frame-consistent value updates.

Parameters:
- DIGITS, 8, number of multiplexed digits (1..16).
- CLK_DIV, 100000, clock cycles each digit is lit (≥1).
- GUARD_CYC, 4, clock cycles of all-anodes-off between digits (≥0; 0 removes the guard state).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_val  in  4*DIGITS  hex nibbles; digit k = i_val[4k+3:4k]; digit 0 is rightmost.
- i_upd  in  1  strobe: capture i_val into the shadow register.
- i_blank  in  DIGITS  per-digit blank mask; 1 = digit dark.
- o_val  out  5  code to the hex segment driver; 5'h00..5'h0F = nibble, 5'h10 = blank (driver outputs all segments off).
- o_anode  out  DIGITS  anode enables, active-low, at most one bit low.
- o_frame  out  1  one-cycle pulse when the last digit's lit period ends.

Behaviour:
- Clocking and reset: one clock domain (i_clk); reset is asynchronous and active-high (i_rst).
- Reset values:
  - shadow = 0, digit index = 0, prescaler = 0, state = SCAN.
  - o_anode = all ones, o_val = 5'h10, o_frame = 0.
- Output registration: all outputs are registered from the current state and index.
  - First lit output (digit 0) appears on the first rising edge after i_rst deasserts.
- FSM states: SCAN, GUARD.
  - SCAN: prescaler counts 0..CLK_DIV-1. o_anode[index] = 0; o_val = shadow nibble of index, or 5'h10 if blanked.
  - SCAN → GUARD when prescaler = CLK_DIV-1. Prescaler clears.
  - If GUARD_CYC = 0, SCAN goes straight back to SCAN and index advances at the same edge.
  - GUARD: prescaler counts 0..GUARD_CYC-1. o_anode = all ones, o_val = 5'h10.
  - On exit from GUARD: index ← (index+1) mod DIGITS; state → SCAN.
- Digit period = CLK_DIV + GUARD_CYC cycles. Frame period = DIGITS × (CLK_DIV + GUARD_CYC).
- Index wrap: DIGITS-1 → 0.
- o_frame pulses high for one cycle, coincident with the SCAN→GUARD (or SCAN→SCAN) transition of index DIGITS-1.
- Blanked digit (i_blank[k] = 1): o_val = 5'h10 and o_anode stays all ones for that digit's SCAN period. Timing is unchanged; the slot is still consumed.
- i_upd handling:
  - Shadow loads i_val on any cycle with i_upd = 1. The new value is visible on o_val one cycle later if the digit is lit.
  - i_upd held high continuously tracks i_val with one-cycle latency.
- i_blank is sampled live, not shadowed.
- Reset mid-scan: immediate return to reset values (asynchronous). No partial frame pulse.
- Widths:
  - Prescaler width = clog2(max(CLK_DIV, GUARD_CYC, 2)).
  - Index width = clog2(max(DIGITS, 2)).

Optional Feature:
- Macro DRV_SEGMENT_SCAN_LZ_EN.
- Defined: leading-zero suppression. Starting from digit DIGITS-1 downward, every digit whose shadow nibble is 0 and whose higher digits are all suppressed is treated as blanked.
  - Digit 0 is never suppressed.
  - Suppression is recomputed from the shadow every cycle.
  - Suppression is ORed with i_blank.
- Undefined: no suppression; zero nibbles display as "0".

Test Plan (DIGITS=4, CLK_DIV=4, GUARD_CYC=2 unless stated):
1. Reset, then i_upd with i_val=16'h1234 → o_anode cycles 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111. o_val=4,3,2,1 during the lit windows. Each lit window is 4 cycles, each guard 2 cycles. o_frame pulses once every 24 cycles.
2. GUARD_CYC=0, i_val=16'hABCD → anodes step with no all-off gap. o_val=D,C,B,A, 4 cycles each. Never more than one anode low.
3. i_blank=4'b0100 → digit 2 slot: o_anode=1111 and o_val=5'h10 for 4 cycles. Other digits are unaffected and frame period stays 24.
4. i_upd pulsed mid-frame with i_val=16'hFFFF while digit 1 is lit → o_val becomes 5'h0F one cycle later. Without i_upd, changes on i_val are never displayed.
5. i_rst asserted during digit 2 SCAN → same-cycle asynchronous o_anode=1111, o_val=5'h10. After release, scanning restarts at digit 0 with a full 4-cycle window.
6. With DRV_SEGMENT_SCAN_LZ_EN defined: i_val=16'h0050 → digits 3 and 2 blanked, digits 1 and 0 show 5 and 0. With i_val=16'h0000 → only digit 0 lit, showing 0.
